// File: rtl/fetch_queue.sv
// fetch_queue: dual-lane in-order instruction buffer between fetch and decode.
// Accepts up to two instructions per cycle and presents the two oldest to
// decode. Each entry carries its PC and an access-fault flag.
module fetch_queue #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush_i,
  input  logic                       fetch_line0_valid_i,
  input  logic [XLEN-1:0]            fetch_line0_instr_i,
  input  logic [XLEN-1:0]            fetch_line0_pc_i,
  input  logic                       fetch_line0_fault_i,
  input  logic                       fetch_line1_valid_i,
  input  logic [XLEN-1:0]            fetch_line1_instr_i,
  input  logic [XLEN-1:0]            fetch_line1_pc_i,
  input  logic                       fetch_line1_fault_i,
  output logic                       fetch_ready_o,
  output logic                       dec_line0_valid_o,
  output logic [XLEN-1:0]            dec_line0_instr_o,
  output logic [XLEN-1:0]            dec_line0_pc_o,
  output logic                       dec_line0_fault_o,
  output logic                       dec_line1_valid_o,
  output logic [XLEN-1:0]            dec_line1_instr_o,
  output logic [XLEN-1:0]            dec_line1_pc_o,
  output logic                       dec_line1_fault_o,
  input  logic                       dec_ready_i,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [XLEN-1:0] instr_mem [DEPTH];
  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic            fault_mem [DEPTH];

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW-1:0] wr_ptr1, rd_ptr1;
  logic [CW-1:0] count;
  logic [CW-1:0] push_n, pop_n;
  logic          push0, push1;

  // Lane-1 indices wrap naturally because DEPTH is a power of two.
  assign wr_ptr1 = wr_ptr + PW'(1);
  assign rd_ptr1 = rd_ptr + PW'(1);

  assign fetch_ready_o = (count <= CW'(DEPTH - 2));

  // Push/pop amounts; lane 1 alone is illegal and is dropped.
  always_comb begin
    push0  = fetch_ready_o && !flush_i && fetch_line0_valid_i;
    push1  = push0 && fetch_line1_valid_i;
    push_n = '0;
    if (push1)      push_n = CW'(2);
    else if (push0) push_n = CW'(1);
    pop_n = '0;
    if (dec_ready_i && !flush_i) begin
      if (count >= CW'(2))      pop_n = CW'(2);
      else if (count == CW'(1)) pop_n = CW'(1);
    end
  end

  // Pointer and occupancy state; reset dominates, flush empties the queue.
  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(push_n);
      rd_ptr <= rd_ptr + PW'(pop_n);
      count  <= count + push_n - pop_n;
    end
  end

  // Storage writes; contents are not reset, validity comes from count.
  always_ff @(posedge clk) begin
    if (!reset && push0) begin
      instr_mem[wr_ptr] <= fetch_line0_instr_i;
      pc_mem[wr_ptr]    <= fetch_line0_pc_i;
      fault_mem[wr_ptr] <= fetch_line0_fault_i;
    end
    if (!reset && push1) begin
      instr_mem[wr_ptr1] <= fetch_line1_instr_i;
      pc_mem[wr_ptr1]    <= fetch_line1_pc_i;
      fault_mem[wr_ptr1] <= fetch_line1_fault_i;
    end
  end

  // Decode view of the two oldest entries.
  always_comb begin
    dec_line0_valid_o = (count >= CW'(1));
    dec_line0_instr_o = instr_mem[rd_ptr];
    dec_line0_pc_o    = pc_mem[rd_ptr];
    dec_line0_fault_o = fault_mem[rd_ptr];
    dec_line1_valid_o = (count >= CW'(2));
    dec_line1_instr_o = instr_mem[rd_ptr1];
    dec_line1_pc_o    = pc_mem[rd_ptr1];
    dec_line1_fault_o = fault_mem[rd_ptr1];
  end

  assign count_o = count;

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Dual-lane in-order instruction buffer between the fetch unit and the two-line decode stage.
- Absorbs up to two fetched instructions per cycle and presents up to two oldest instructions per cycle to decode.
- Carries the PC and a fetch access-fault flag with each instruction.
- Decouples fetch from decode/rename back-pressure; emptied on pipeline flush.

Parameters:
- XLEN, 32, instruction and PC width.
- DEPTH, 8, number of entries; power of two, >= 4.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- flush_i  in  1  pipeline flush; discards all entries
- fetch_line0_valid_i  in  1  lane 0 carries an instruction
- fetch_line0_instr_i  in  XLEN  lane 0 instruction
- fetch_line0_pc_i  in  XLEN  lane 0 PC
- fetch_line0_fault_i  in  1  lane 0 instruction access fault
- fetch_line1_valid_i  in  1  lane 1 carries an instruction (younger than lane 0)
- fetch_line1_instr_i  in  XLEN  lane 1 instruction
- fetch_line1_pc_i  in  XLEN  lane 1 PC
- fetch_line1_fault_i  in  1  lane 1 instruction access fault
- fetch_ready_o  out  1  queue accepts a push this cycle
- dec_line0_valid_o  out  1  oldest entry present
- dec_line0_instr_o  out  XLEN  oldest entry instruction
- dec_line0_pc_o  out  XLEN  oldest entry PC
- dec_line0_fault_o  out  1  oldest entry fault
- dec_line1_valid_o  out  1  second-oldest entry present
- dec_line1_instr_o  out  XLEN  second-oldest entry instruction
- dec_line1_pc_o  out  XLEN  second-oldest entry PC
- dec_line1_fault_o  out  1  second-oldest entry fault
- dec_ready_i  in  1  decode consumes every presented valid lane this cycle
- count_o  out  $clog2(DEPTH)+1  current occupancy

Behaviour:
- State:
  - Storage array of DEPTH entries of {instr, pc, fault}.
  - wr_ptr and rd_ptr, each $clog2(DEPTH) bits, wrapping modulo DEPTH.
  - count, 0..DEPTH.
- Reset (reset=1 at a clk edge):
  - wr_ptr, rd_ptr and count go to 0.
  - Storage contents are not reset.
  - Resulting outputs: fetch_ready_o=1, both dec valids=0, count_o=0.
  - Reset dominates flush, push and pop in the same cycle.
- fetch_ready_o = (DEPTH - count >= 2).
  - Computed from registered count only.
  - Does not depend on the same-cycle pop or on any input.
- Push, when fetch_ready_o=1 and flush_i=0:
  - lane0 valid only: write lane 0 at wr_ptr; wr_ptr+=1.
  - lane0 and lane1 valid: write lane 0 at wr_ptr and lane 1 at wr_ptr+1; wr_ptr+=2.
  - lane1 valid with lane0 invalid: illegal; lane 1 is dropped and nothing is written.
  - When fetch_ready_o=0, inputs are ignored. Fetch must hold its lanes.
- Decode outputs:
  - Driven combinationally from storage at rd_ptr and rd_ptr+1.
  - dec_line0_valid_o = count>=1; dec_line1_valid_o = count>=2.
  - Data on an invalid lane is don't-care.
- Pop, when dec_ready_i=1 and flush_i=0:
  - Removes min(count,2) entries; rd_ptr advances by the same amount.
  - dec_ready_i with count=0 has no effect.
- Same-cycle push and pop:
  - count_next = count + pushed - popped.
  - Never overflows, because ready is checked against the pre-pop count.
  - Never underflows.
- Latency: an entry pushed in cycle N is visible on the decode outputs in cycle N+1 at the earliest. There is no same-cycle bypass.
- Ordering: strict FIFO. Lane 0 output is always older than lane 1 output.
- Pointer wrap:
  - The lane-1 read/write index is (ptr+1) mod DEPTH.
  - A two-wide push at wr_ptr=DEPTH-1 writes entries DEPTH-1 and 0.
- Flush (flush_i=1):
  - Next cycle: count=0 and rd_ptr=wr_ptr (both to 0).
  - Any push or pop in the flush cycle is discarded.
  - Decode outputs during the flush cycle still show pre-flush state; consumers gate them with flush.
- Full (count=DEPTH) and count=DEPTH-1 both give fetch_ready_o=0.
- count_o = count (registered).
- Fault bit is carried unchanged with its instruction; the queue takes no action on it.

Test Plan:
- Reset then push lanes {0x00000013@0x100, 0x00100093@0x104} -> next cycle dec line0 pc=0x100, line1 pc=0x104, both valid, count_o=2; pop with dec_ready_i=1 -> count_o=0, valids=0.
- Push pairs every cycle with dec_ready_i=0, DEPTH=8 -> count_o 2,4,6; ready drops at count 8 (ready=0 at 7 also tested via single push); queue contents unchanged while held.
- Full queue (8 entries), dec_ready_i=1 and fetch pair asserted same cycle -> push refused (ready=0), count 8->6; next cycle ready=1 and pair accepted, count 6->6.
- Wrap: advance pointers so wr_ptr=7, push pair pc 0x200/0x204 -> both pop in order after older entries with correct instr/pc/fault; single-entry count=1 pop leaves count=0.
- Flush with count=5 plus simultaneous push pair -> next cycle count_o=0, valids=0, ready=1; pushed pair never appears.
- Reset asserted mid-traffic with push and pop active -> next cycle count_o=0, both valids 0; lane1-only push (line0 invalid) -> count unchanged.
